// File: rtl/mul_add_arbiter.sv
// mul_add_arbiter
// ---------------
// Shares a single floating-point mul_add unit between NUM_REQ requesters.
// Requests are arbitrated round-robin and only one operation is in flight at a
// time. The result goes back to the granted requester as a one-cycle strobe. A
// done-timeout watchdog clears a hung unit and reports an error response.
//
// Ports
//   clk          system clock, rising edge
//   aclr_n       asynchronous active-low reset
//   req_valid    per-requester operation request
//   req_dataa    packed operand a, requester i at [i*DATA_W +: DATA_W]
//   req_datab    packed operand b, same packing
//   req_ready    one-hot accept strobe (combinational, IDLE only)
//   rsp_valid    one-hot one-cycle response strobe
//   rsp_result   response data, held until the next response
//   rsp_error    response came from a watchdog timeout
//   busy         an operation is in progress
//   grant_id     index of the current/last granted requester
//   unit_clk_en  clock enable to the mul_add unit
//   unit_aclr    active-high clear to the mul_add unit
//   unit_start   one-cycle issue strobe to the unit
//   unit_dataa   registered operand a to the unit
//   unit_datab   registered operand b to the unit
//   unit_result  result from the unit
//   unit_done    completion flag from the unit
module mul_add_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        aclr_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_dataa,
  input  logic [NUM_REQ*DATA_W-1:0]   req_datab,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_result,
  output logic                        rsp_error,
  output logic                        busy,
  output logic [GRANT_W-1:0]          grant_id,
  output logic                        unit_clk_en,
  output logic                        unit_aclr,
  output logic                        unit_start,
  output logic [DATA_W-1:0]           unit_dataa,
  output logic [DATA_W-1:0]           unit_datab,
  input  logic [DATA_W-1:0]           unit_result,
  input  logic                        unit_done
);

  // Watchdog counts 0..TIMEOUT-1 while waiting for done.
  localparam int WDOG_W = $clog2(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(NUM_REQ - 1);
  localparam logic [WDOG_W-1:0]  WDOG_MAX = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [GRANT_W-1:0]    last_grant_r;
  logic [GRANT_W-1:0]    last_grant_next_s;
  logic [GRANT_W-1:0]    grant_id_r;
  logic [GRANT_W-1:0]    grant_next_s;
  logic [DATA_W-1:0]     dataa_r;
  logic [DATA_W-1:0]     dataa_next_s;
  logic [DATA_W-1:0]     datab_r;
  logic [DATA_W-1:0]     datab_next_s;
  logic [WDOG_W-1:0]     wdog_r;
  logic [WDOG_W-1:0]     wdog_next_s;
  logic [DATA_W-1:0]     rsp_result_r;
  logic [DATA_W-1:0]     result_next_s;
  logic                  rsp_error_r;
  logic                  error_next_s;
  logic [NUM_REQ-1:0]    rsp_valid_r;
  logic                  unit_start_r;
  logic                  unit_clk_en_r;
  logic                  aclr_pulse_r;
  logic                  busy_r;
  logic                  fire_s;

  logic                  found_s;
  logic [GRANT_W-1:0]    winner_s;
  logic [GRANT_W-1:0]    cand_s;
  logic                  hit_s;
  logic [DATA_W-1:0]     sel_a_s;
  logic [DATA_W-1:0]     sel_b_s;

  // Round-robin search starting one past the last served requester, with wrap.
  // The wrap compare keeps the index legal for non-power-of-two NUM_REQ.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    cand_s   = last_grant_r;
    hit_s    = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s   = (cand_s == LAST_IDX) ? '0 : cand_s + 1'b1;
      hit_s    = ~found_s & req_valid[cand_s];
      winner_s = hit_s ? cand_s : winner_s;
      found_s  = found_s | hit_s;
    end
  end

  // AND-OR operand mux selecting the winner's packed operands.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_s = sel_a_s | (req_dataa[i*DATA_W +: DATA_W] & {DATA_W{winner_s == GRANT_W'(i)}});
      sel_b_s = sel_b_s | (req_datab[i*DATA_W +: DATA_W] & {DATA_W{winner_s == GRANT_W'(i)}});
    end
  end

  // Next-state and next register values for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_next_s      = state_r;
    last_grant_next_s = last_grant_r;
    grant_next_s      = grant_id_r;
    dataa_next_s      = dataa_r;
    datab_next_s      = datab_r;
    wdog_next_s       = wdog_r;
    result_next_s     = rsp_result_r;
    error_next_s      = rsp_error_r;
    fire_s            = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_next_s = ISSUE;
          grant_next_s = winner_s;
          dataa_next_s = sel_a_s;
          datab_next_s = sel_b_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = WAIT;
        wdog_next_s  = '0;
      end
      WAIT: begin
        wdog_next_s = wdog_r + 1'b1;
        // done takes precedence over a coinciding timeout
        if (unit_done) begin
          state_next_s  = RESP;
          result_next_s = unit_result;
          error_next_s  = 1'b0;
        end else if (wdog_r == WDOG_MAX) begin
          state_next_s  = RESP;
          result_next_s = '0;
          error_next_s  = 1'b1;
          fire_s        = 1'b1;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP: begin
        last_grant_next_s = grant_id_r;
        state_next_s      = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State and output registers; strobes are registered from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_r       <= IDLE;
      last_grant_r  <= LAST_IDX;
      grant_id_r    <= '0;
      dataa_r       <= '0;
      datab_r       <= '0;
      wdog_r        <= '0;
      rsp_result_r  <= '0;
      rsp_error_r   <= 1'b0;
      rsp_valid_r   <= '0;
      unit_start_r  <= 1'b0;
      unit_clk_en_r <= 1'b0;
      aclr_pulse_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      last_grant_r  <= last_grant_next_s;
      grant_id_r    <= grant_next_s;
      dataa_r       <= dataa_next_s;
      datab_r       <= datab_next_s;
      wdog_r        <= wdog_next_s;
      rsp_result_r  <= result_next_s;
      rsp_error_r   <= error_next_s;
      rsp_valid_r   <= (state_next_s == RESP) ? (ONE_HOT0 << grant_next_s) : '0;
      unit_start_r  <= (state_next_s == ISSUE);
      unit_clk_en_r <= (state_next_s == ISSUE) || (state_next_s == WAIT);
      aclr_pulse_r  <= fire_s;
      busy_r        <= (state_next_s != IDLE);
    end
  end

  assign req_ready   = ((state_r == IDLE) && found_s) ? (ONE_HOT0 << winner_s) : '0;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_result  = rsp_result_r;
  assign rsp_error   = rsp_error_r;
  assign busy        = busy_r;
  assign grant_id    = grant_id_r;
  assign unit_clk_en = unit_clk_en_r;
  // Unit is held in clear throughout our own reset, plus the watchdog pulse.
  assign unit_aclr   = ~aclr_n | aclr_pulse_r;
  assign unit_start  = unit_start_r;
  assign unit_dataa  = dataa_r;
  assign unit_datab  = datab_r;

endmodule

// File: doc/mul_add_arbiter.md
Name: mul_add_arbiter

Overview:
- Shares one floating-point mul_add unit between NUM_REQ requesters (e.g. CORDIC stages and a custom-instruction port).
- Arbitrates round-robin, allows one operation in flight at a time, and forwards operands to the unit.
- Returns the result to the granted requester, with a done-timeout watchdog that clears a hung unit.
- Sits between the custom-instruction/CORDIC control logic and the mul_add instance.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4)
- DATA_W, 32, operand/result width (IEEE-754 single)
- TIMEOUT, 64, max WAIT cycles before the watchdog fires (legal >= 2)
- GRANT_W, clog2(NUM_REQ), grant index width

Ports:
- clk  in  1  system clock, all logic on rising edge
- aclr_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_dataa  in  NUM_REQ*DATA_W  packed operand a; requester i in bits [i*DATA_W +: DATA_W]
- req_datab  in  NUM_REQ*DATA_W  packed operand b, same packing
- req_ready  out  NUM_REQ  one-hot accept strobe
- rsp_valid  out  NUM_REQ  one-hot one-cycle response strobe
- rsp_result  out  DATA_W  result; valid while any rsp_valid bit is high
- rsp_error  out  1  high with rsp_valid when the watchdog fired
- busy  out  1  high in every state except IDLE
- grant_id  out  GRANT_W  index of current/last granted requester
- unit_clk_en  out  1  drives mul_add clk_en
- unit_aclr  out  1  drives mul_add aclr (active-high)
- unit_start  out  1  one-cycle issue strobe to the unit
- unit_dataa  out  DATA_W  registered operand a to the unit
- unit_datab  out  DATA_W  registered operand b to the unit
- unit_result  in  DATA_W  mul_add result
- unit_done  in  1  mul_add done

Behaviour:
- Reset (aclr_n low, asynchronous):
  - state = IDLE; every registered output clears to 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - unit_aclr = 1 for as long as aclr_n is low.
- Reset mid-operation: the in-flight operation is dropped and no rsp_valid is produced.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[winner] = 1, combinational, only in IDLE. Accept happens in that cycle.
  - On accept: latch the winner's operands into unit_dataa/unit_datab, set grant_id = winner, go to ISSUE.
  - With no req_valid, stay in IDLE; req_ready = 0.
- ISSUE (one cycle): unit_start = 1, unit_clk_en = 1, wdog = 0, go to WAIT.
- WAIT:
  - unit_clk_en = 1; wdog increments each cycle.
  - If unit_done = 1: latch unit_result into rsp_result, set rsp_error = 0, go to RESP.
  - Else, if wdog == TIMEOUT-1: set rsp_result = 0, rsp_error = 1, pulse unit_aclr for exactly 1 cycle, go to RESP.
  - If unit_done and the timeout coincide, done wins: success, no unit_aclr pulse.
- RESP (one cycle):
  - rsp_valid[grant_id] = 1. There is no response backpressure; the requester must capture it.
  - last_grant = grant_id; go to IDLE.
  - rsp_result and rsp_error hold their values until the next RESP.
- unit_done is ignored outside WAIT.
- unit_clk_en = 0 in IDLE and RESP.
- Timing:
  - Accept in cycle A; unit_start in A+1.
  - If the unit asserts done in cycle A+1+k (k >= 1), rsp_valid is high in A+2+k.
  - Next accept is no earlier than A+3+k. Throughput: one operation per (k+3) cycles.
- Operands are sampled only at accept. Later changes on req_data* do not affect an in-flight operation.
- A requester that drops req_valid before being granted is simply skipped. No state is kept per pending request.
- busy = (state != IDLE).

Test Plan:
- Single operation: req0 with dataa=0x3F0B851F, datab=0x40AA60FE; stub raises done 4 cycles after unit_start with result 0x41039E04.
  - req_ready[0] pulses once.
  - unit_start pulses once with the same operands.
  - rsp_valid[0] is a single pulse 6 cycles after accept, with rsp_result=0x41039E04 and rsp_error=0.
- Contention: req0 and req1 held high for 4 operations -> grant_id sequence 0,1,0,1, and rsp_valid matches each grant.
- Hung unit, TIMEOUT=8: done never asserted.
  - rsp_valid after 8 WAIT cycles with rsp_result=0, rsp_error=1.
  - unit_aclr is high for exactly one cycle.
  - The following request completes normally with rsp_error=0.
- Reset mid-WAIT: drop aclr_n for 3 cycles.
  - All outputs go to 0 immediately and unit_aclr stays high while aclr_n is low.
  - No rsp_valid is produced.
  - After release with both requesting, requester 0 is granted first.
- Corner handshakes:
  - unit_done pulsed in IDLE is ignored; busy stays 0.
  - With TIMEOUT=8, done on the 8th WAIT cycle gives a success response with no unit_aclr pulse.
  - Changing req_dataa after accept leaves unit_dataa unchanged.
